// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution window controller and its bench.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } conv_state_e;

  localparam int K_DEFAULT     = 3;
  localparam int IMG_W_DEFAULT = 16;
  localparam int IMG_H_DEFAULT = 16;

  // Number of valid KxK windows in a w x h frame.
  function automatic int win_count(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

// File: rtl/conv_window_ctrl.sv
// Raster-stream sequencer for the shift/line-buffer datapath: drives shifts,
// tracks pixel position and flags each completed KxK window with its coordinates.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int DW    = 16,
  parameter int K     = K_DEFAULT,
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          shift_en,
  output logic [DW-1:0] shift_data,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          win_last
);

  conv_state_e   state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          win_last_q, win_last_d;
  logic          done_q, done_d;

  logic accept;
  logic col_end;
  logic row_end;
  logic last_pix;
  logic win_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
      done_q      <= done_d;
    end
  end

  // A pending window blocks the source unless it is consumed this same cycle.
  always_comb begin
    in_ready   = ((state_q == FILL) || (state_q == RUN)) && (!win_valid_q || win_ready);
    accept     = in_valid && in_ready;
    shift_en   = accept;
    shift_data = accept ? in_data : '0;
    busy       = (state_q != IDLE);
  end

  assign col_end  = (col_q == CW'(IMG_W - 1));
  assign row_end  = (row_q == RW'(IMG_H - 1));
  assign last_pix = accept && col_end && row_end;
  assign win_fire = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL: begin
        if (last_pix)      state_d = DRAIN;
        else if (win_fire) state_d = RUN;
      end
      RUN:   if (last_pix) state_d = DRAIN;
      DRAIN: begin
        if (win_valid_q && win_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if ((state_q == IDLE) && start) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Subtraction only happens when win_fire guarantees row/col >= K-1.
  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;
    if (win_fire) begin
      win_valid_d = 1'b1;
      win_row_d   = row_q - RW'(K - 1);
      win_col_d   = col_q - CW'(K - 1);
      win_last_d  = last_pix;
    end else if (win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: a driver queues expected shifts and
// windows per accepted pixel, a monitor pops and compares them as the DUT emits.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int CW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          win_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          busy, done, in_ready, shift_en, win_valid, win_last;
  logic [DW-1:0] shift_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;

  conv_window_ctrl #(.DW(DW), .K(K), .IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_en(shift_en), .shift_data(shift_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
    .win_col(win_col), .win_last(win_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int r;
    int c;
    int last;
  } win_t;

  win_t wq[$];
  int   sq[$];
  int   nvec = 0;
  int   nerr = 0;
  int   nwin, nshift, first_win_cyc, acc34_cyc;
  int   row_cnt[H];
  bit   exp_done = 1'b0;
  bit   done_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int i);
    return DW'(i * 37 + 5);
  endfunction

  // Monitor: samples mid-cycle, after the driver has queued this cycle's accept.
  initial begin
    win_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (exp_done || done) begin
          chk("done_pulse", done, exp_done);
          if (done) chk("busy_at_done", busy, 0);
          if (done && exp_done) done_seen = 1'b1;
        end
        exp_done = 1'b0;
        if (shift_en) begin
          nshift++;
          if (sq.size() == 0) chk("shift_spurious", shift_en, 0);
          else chk("shift_data", shift_data, sq.pop_front());
        end else begin
          chk("shift_data_idle", shift_data, 0);
        end
        if (win_valid && first_win_cyc < 0) first_win_cyc = cyc;
        if (win_valid && win_ready) begin
          nwin++;
          if (wq.size() == 0) begin
            chk("win_spurious", win_valid, 0);
          end else begin
            e = wq.pop_front();
            chk("win_row", win_row, e.r);
            chk("win_col", win_col, e.c);
            chk("win_last", win_last, e.last);
            row_cnt[int'(win_row)]++;
            if (e.last != 0) exp_done = 1'b1;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
  task automatic drive_pixel(input int i, input bit gap, input bit want_ready_now);
    int r;
    int c;
    bit ok;
    r = i / W;
    c = i % W;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = pix(i);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (want_ready_now && t == 0) chk("bp_release_ready", in_ready, 1);
      if (in_ready) begin
        ok = 1'b1;
        sq.push_back(int'(pix(i)));
        if (r >= K - 1 && c >= K - 1)
          wq.push_back('{r - (K - 1), c - (K - 1), int'(i == W * H - 1)});
        if (i == (K - 1) * W + (K - 1)) acc34_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (!ok) begin
      chk("ready_timeout", in_ready, 1);
    end else begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_frame(input int npix, input bit gap, input bit bp,
                           input bit mid_start, input bit rows_chk);
    nwin = 0;
    nshift = 0;
    first_win_cyc = -1;
    acc34_cyc = -100;
    done_seen = 1'b0;
    foreach (row_cnt[j]) row_cnt[j] = 0;
    chk("busy_idle", busy, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_started", busy, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < npix; i++) begin
      if (mid_start && i == 100) start = 1'b1;
      if (bp && i == 6 * W + 10) begin
        win_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pix(i);
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_shift_en", shift_en, 0);
          chk("bp_win_valid", win_valid, 1);
          chk("bp_win_row", win_row, 4);
          chk("bp_win_col", win_col, 7);
          chk("bp_win_last", win_last, 0);
          @(posedge clk);
          #1;
        end
        win_ready = 1'b1;
        drive_pixel(i, gap, 1'b1);
      end else begin
        drive_pixel(i, gap, 1'b0);
      end
    end
    if (npix == W * H) begin
      in_valid = 1'b0;
      for (int t = 0; t < 40 && !done_seen; t++) begin
        @(posedge clk);
        #1;
      end
      chk("done_seen", done_seen, 1);
      chk("win_count", nwin, win_count(W, H, K));
      chk("shift_count", nshift, W * H);
      chk("busy_end", busy, 0);
      chk("first_win_cyc", first_win_cyc, acc34_cyc + 1);
      chk("wq_empty", wq.size(), 0);
      chk("sq_empty", sq.size(), 0);
      if (rows_chk)
        for (int j = 0; j <= H - K; j++) chk("row_windows", row_cnt[j], W - K + 1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_shift_en"}, shift_en, 0);
    chk({tag, "_shift_data"}, shift_data, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win_last"}, win_last, 0);
    chk({tag, "_win_row"}, win_row, 0);
    chk({tag, "_win_col"}, win_col, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk_all_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pixels offered while idle must be ignored.
    in_valid = 1'b1;
    in_data  = 16'd100;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_shift_en", shift_en, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    run_frame(W * H, 1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(W * H, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(W * H, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort a frame after 50 pixels.
    run_frame(50, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    sq.delete();
    wq.delete();
    exp_done = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(W * H, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
